// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch unit control, memory and delivery signal bundle
interface fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_e;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, mem_instr,
        output mem_e, mem_addr, instr_out, pc_out, instr_valid, fault, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, mem_instr,
        input  mem_e, mem_addr, instr_out, pc_out, instr_valid, fault, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-issue instruction fetch with stall, branch redirect and range fault
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam logic [31:0] DEPTH32   = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] pc_q, pc_q_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;
    logic        issue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            pc_q    <= pc_q_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        pc_q_d  = pc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        issue   = 1'b0;
        case (state)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.branch_taken) begin
                    // Redirect beats stall; the instruction on the output is squashed, not delivered.
                    valid_d = 1'b0;
                    if (bus.branch_target < DEPTH32) begin
                        pc_d = bus.branch_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (!bus.stall) begin
                    issue   = 1'b1;
                    pc_q_d  = pc;
                    valid_d = 1'b1;
                    pc_d    = (pc == LAST_ADDR) ? 32'd0 : pc + 32'd1;
                    if (valid_q) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // Gated by rst_n so nothing leaks out while reset is held, before the registers clear.
    assign bus.mem_e       = rst_n & issue;
    assign bus.mem_addr    = pc;
    assign bus.instr_out   = bus.mem_instr;
    assign bus.pc_out      = pc_q;
    assign bus.instr_valid = rst_n & valid_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;
endmodule
